// File: rtl/gray_step_ctrl_if.sv
// Command channel of the Gray-code step controller: {direction, step-count}
// offered under a valid/ready handshake.
interface gray_step_ctrl_if #(
  parameter int STEP_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;

  modport master (output cmd_valid, output cmd_dir, output cmd_steps, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_dir, input  cmd_steps, output cmd_ready);
endinterface

// File: rtl/gray_step_ctrl.sv
// Command sequencer for an up/down modulo-2^WIDTH Gray-code counter with optional dwell.
// Optional feature macro GSC_WRAP_CNT_EN adds a saturating wrap counter output wrap_cnt.
module gray_step_ctrl #(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 4,
  parameter int DWELL  = 0
) (
  input  logic             clk,
  input  logic             reset,
  gray_step_ctrl_if.slave  cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
`ifdef GSC_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  localparam int DW_W = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [WIDTH-1:0]  gray_q, gray_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic              dir_q, dir_d;
  logic              aborted_q, aborted_d;
  logic              wrap_q, wrap_d;
  logic              accept;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] step_bin(input logic [WIDTH-1:0] b, input logic up);
    return up ? b + 1'b1 : b - 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    rem_d     = rem_q;
    dwell_d   = dwell_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    wrap_d    = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          accept    = 1'b1;
          dir_d     = cmd.cmd_dir;
          rem_d     = cmd.cmd_steps;
          aborted_d = 1'b0;
          state_d   = (cmd.cmd_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Abort pre-empts the step due on this edge, including the final one.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          bin_d  = step_bin(bin_q, dir_q);
          wrap_d = dir_q ? (bin_q == '1) : (bin_q == '0);
          rem_d  = rem_q - 1'b1;
          if (rem_q == STEP_W'(1)) begin
            state_d = S_DONE;
          end else if (DWELL > 0) begin
            dwell_d = DW_W'(DWELL);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          dwell_d = dwell_q - 1'b1;
          if (dwell_q == DW_W'(1)) state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    gray_d = to_gray(bin_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      gray_q    <= '0;
      rem_q     <= '0;
      dwell_q   <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      rem_q     <= rem_d;
      dwell_q   <= dwell_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      wrap_q    <= wrap_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q == S_RUN) || (state_q == S_WAIT);
  assign done          = (state_q == S_DONE);
  assign aborted       = aborted_q;
  assign wrap          = wrap_q;
  assign gray          = gray_q;

`ifdef GSC_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (accept)                             wrap_cnt_d = '0;
    else if (wrap_q && wrap_cnt_q != 8'hFF) wrap_cnt_d = wrap_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_cnt_q <= '0;
    else        wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
